counter_multi_ch: RTL and testbench

COUNTER_MULTI_CH -- requirements
Module: counter_multi_ch

---
 rtl/counter_pkg.sv | 38 +++
 rtl/counter_channel.sv | 80 ++++++++
 rtl/counter_multi_ch.sv | 78 +++++++
 tb/tb_counter_multi_ch.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and helpers for the multi-channel counter.
// Holds the direction encoding, the legal parameter ranges and the
// per-channel operation decode used by counter_channel.
package counter_pkg;

    // Direction encoding on up_dn
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Legal parameter ranges
    localparam int unsigned WIDTH_MIN    = 2;
    localparam int unsigned WIDTH_MAX    = 32;
    localparam int unsigned NUM_CH_MIN   = 1;
    localparam int unsigned NUM_CH_MAX   = 16;
    localparam int unsigned PRESCALE_MIN = 2;
    localparam int unsigned PRESCALE_MAX = 256;

    // Operation selected for a channel on a given edge
    typedef enum logic [1:0] {
        OP_HOLD  = 2'd0,
        OP_COUNT = 2'd1,
        OP_LOAD  = 2'd2,
        OP_CLR   = 2'd3
    } ch_op_e;

    // Priority decode: clear beats load beats a qualified count step
    function automatic ch_op_e decode_op(input logic clr,
                                         input logic load,
                                         input logic step);
        ch_op_e op;
        if (clr)       op = OP_CLR;
        else if (load) op = OP_LOAD;
        else if (step) op = OP_COUNT;
        else           op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one independent up/down counter with a registered
// terminal-count pulse and a sticky overflow/underflow flag.
// SATURATE=0 wraps modulo 2^WIDTH, SATURATE=1 holds at the limit.
module counter_channel
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             tick,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             at_limit;
    ch_op_e           op;

    // Next-state: priority decode, limit detection and wrap/saturate step
    always_comb begin
        op       = decode_op(clr, load, en & tick);
        at_limit = (up_dn == CNT_UP) ? (cnt_q == '1) : (cnt_q == '0);
        cnt_d    = cnt_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        unique case (op)
            OP_CLR: begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end
            OP_LOAD: begin
                cnt_d = load_val;
            end
            OP_COUNT: begin
                if (at_limit) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
                if (at_limit && (SATURATE != 0)) begin
                    cnt_d = cnt_q;
                end else if (up_dn == CNT_UP) begin
                    cnt_d = cnt_q + WIDTH'(1);
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // State registers, cleared asynchronously by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/counter_multi_ch.sv
// counter_multi_ch: NUM_CH independent WIDTH-bit counters sharing one clock.
// Optional feature macro COUNTER_MULTI_CH_PRESCALE_EN adds parameter
// PRESCALE and a shared free-running prescaler that qualifies count steps;
// without it every enabled cycle is a count step.
module counter_multi_ch
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SATURATE = 0
`ifdef COUNTER_MULTI_CH_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE = 4
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] load_val,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       up_dn,
    output logic [NUM_CH*WIDTH-1:0] q,
    output logic [NUM_CH-1:0]       tc,
    output logic [NUM_CH-1:0]       ovf
);

    logic tick;

`ifdef COUNTER_MULTI_CH_PRESCALE_EN
    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;

    // tick fires when the prescaler reaches its last state, i.e. on the
    // PRESCALE-th edge after reset release and every PRESCALE edges after
    assign tick = (ps_q == PS_W'(PRESCALE - 1));

    // Prescaler next-state: count 0..PRESCALE-1 then restart
    always_comb begin
        ps_d = ps_q + PS_W'(1);
        if (tick) begin
            ps_d = '0;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH   (WIDTH),
            .SATURATE(SATURATE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .clr     (clr[i]),
            .load    (load[i]),
            .load_val(load_val[i*WIDTH +: WIDTH]),
            .en      (en[i]),
            .tick    (tick),
            .up_dn   (up_dn[i]),
            .q       (q[i*WIDTH +: WIDTH]),
            .tc      (tc[i]),
            .ovf     (ovf[i])
        );
    end

endmodule

// File: tb/tb_counter_multi_ch.sv
// tb_counter_multi_ch: scoreboard bench for counter_multi_ch.
// Stimulus pushes hand-computed expectations tagged with the cycle they
// become valid; a monitor pops and compares them away from the clock edge.
module tb_counter_multi_ch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // Wrapping instance, 2 channels
    logic [1:0] clr = '0, load = '0, en = '0, up_dn = '0;
    logic [7:0] load_val = '0;
    logic [7:0] q;
    logic [1:0] tc, ovf;

    // Saturating instance, 1 channel
    logic [0:0] s_clr = '0, s_load = '0, s_en = '0, s_up = '0;
    logic [3:0] s_lv = '0;
    logic [3:0] s_q;
    logic [0:0] s_tc, s_ovf;

    counter_multi_ch #(.WIDTH(4), .NUM_CH(2), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up_dn(up_dn), .q(q), .tc(tc), .ovf(ovf)
    );

    counter_multi_ch #(.WIDTH(4), .NUM_CH(1), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .clr(s_clr), .load(s_load), .load_val(s_lv),
        .en(s_en), .up_dn(s_up), .q(s_q), .tc(s_tc), .ovf(s_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        bit         sel;
        logic [7:0] eq;
        logic [1:0] etc;
        logic [1:0] eovf;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    event kick;

    // Monitor: compare every expectation whose cycle has arrived
    initial begin
        forever begin
            @(negedge clk or kick);
            #1;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                logic [7:0] aq;
                logic [1:0] atc, aovf;
                e = sb.pop_front();
                if (e.sel) begin
                    aq = {4'h0, s_q}; atc = {1'b0, s_tc}; aovf = {1'b0, s_ovf};
                end else begin
                    aq = q; atc = tc; aovf = ovf;
                end
                checks++;
                if (aq !== e.eq || atc !== e.etc || aovf !== e.eovf) begin
                    errors++;
                    $display("FAIL %s: got q=%h tc=%b ovf=%b, expected q=%h tc=%b ovf=%b",
                             e.name, aq, atc, aovf, e.eq, e.etc, e.eovf);
                end
            end
        end
    end

    task automatic push(input int due, input bit sel, input logic [7:0] eq,
                        input logic [1:0] etc, input logic [1:0] eovf, input string nm);
        exp_t e;
        e.due = due; e.sel = sel; e.eq = eq; e.etc = etc; e.eovf = eovf; e.name = nm;
        sb.push_back(e);
    endtask

    // Called at a negedge: drive the wrapping instance, expect result after next posedge
    task automatic step_m(input logic [1:0] c, input logic [1:0] l, input logic [7:0] lv,
                          input logic [1:0] e, input logic [1:0] u, input bit chk,
                          input logic [7:0] eq, input logic [1:0] etc,
                          input logic [1:0] eovf, input string nm);
        clr = c; load = l; load_val = lv; en = e; up_dn = u;
        s_clr = '0; s_load = '0; s_en = '0; s_up = '0;
        if (chk) push(cyc + 1, 1'b0, eq, etc, eovf, nm);
        @(negedge clk);
    endtask

    // Called at a negedge: drive the saturating instance, wrapping one idles
    task automatic step_s(input logic c, input logic l, input logic [3:0] lv,
                          input logic e, input logic u,
                          input logic [3:0] eq, input logic etc, input logic eovf,
                          input string nm);
        clr = '0; load = '0; en = '0; up_dn = '0;
        s_clr = c; s_load = l; s_lv = lv; s_en = e; s_up = u;
        push(cyc + 1, 1'b1, {4'h0, eq}, {1'b0, etc}, {1'b0, eovf}, nm);
        @(negedge clk);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Reset state
        step_m(2'b00, 2'b00, 8'h00, 2'b11, 2'b11, 1, 8'h00, 2'b00, 2'b00, "reset_state");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, "reset_state_s");

`ifdef COUNTER_MULTI_CH_PRESCALE_EN
        // Prescaled counting: one step every 4 cycles
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, (k % 4 == 0) || (k == 3),
                   {4'h0, 4'(k / 4)}, 2'b00, 2'b00, "prescale");
        end
`else
        // Release and up-count ch0 through the wrap
        rst = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, {4'h0, 4'(k % 16)},
                   (k == 16) ? 2'b01 : 2'b00, (k == 16) ? 2'b01 : 2'b00, "up_run");
        end
        step_m(2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 1, 8'h00, 2'b00, 2'b01, "tc_once");
        step_m(2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 1, 8'hF0, 2'b10, 2'b11, "dn_wrap");
        step_m(2'b00, 2'b00, 8'h00, 2'b11, 2'b01, 1, 8'hE1, 2'b00, 2'b11, "indep");
        step_m(2'b01, 2'b11, 8'h59, 2'b00, 2'b00, 1, 8'h50, 2'b00, 2'b10, "clr_load");
        step_m(2'b00, 2'b01, 8'h03, 2'b11, 2'b11, 1, 8'h63, 2'b00, 2'b10, "load_pri");
        step_m(2'b00, 2'b01, 8'h0F, 2'b00, 2'b00, 1, 8'h6F, 2'b00, 2'b10, "load_top");
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h60, 2'b01, 2'b11, "wrap_tc");
        step_m(2'b00, 2'b01, 8'h02, 2'b10, 2'b00, 1, 8'h52, 2'b00, 2'b11, "load_no_tc");
        step_m(2'b01, 2'b00, 8'h00, 2'b11, 2'b01, 1, 8'h40, 2'b00, 2'b10, "clr_pri");

        // Saturating instance
        step_s(1'b0, 1'b1, 4'hE, 1'b0, 1'b1, 4'hE, 1'b0, 1'b0, "sat_load");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0, "sat_up1");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, "sat_up2");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, "sat_up3");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'hE, 1'b0, 1'b1, "sat_dn");
        step_s(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, "sat_load0");
        step_s(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, "sat_floor");
        step_s(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, "sat_clr");

        // Mid-count asynchronous reset
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h41, 2'b00, 2'b10, "pre_rst1");
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h42, 2'b00, 2'b10, "pre_rst2");
        #2;
        rst = 1'b0;
        push(cyc, 1'b0, 8'h00, 2'b00, 2'b00, "async_rst");
        ->kick;
        @(negedge clk);
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h00, 2'b00, 2'b00, "rst_hold");
        rst = 1'b1;
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h01, 2'b00, 2'b00, "first_inc");
        step_m(2'b00, 2'b00, 8'h00, 2'b01, 2'b01, 1, 8'h02, 2'b00, 2'b00, "second_inc");
`endif

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(negedge clk);
            #2;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
